// File: rtl/renode_ahb_sram_subordinate.sv
// AHB-Lite subordinate backed by a word-organised on-chip memory.
// Handles byte/halfword/word transfers, a fixed number of wait states on every
// OKAY data phase, and the two-cycle ERROR response for illegal accesses.
module renode_ahb_sram_subordinate #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA
);

    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    // One bit wider than HADDR so the limit itself is representable.
    localparam logic [ADDR_WIDTH:0] BYTE_LIMIT = (ADDR_WIDTH + 1)'(4 * MEM_WORDS);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    if (DATA_WIDTH != 32) begin : g_bad_data_width
        $error("renode_ahb_sram_subordinate: DATA_WIDTH must be 32");
    end
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
        $error("renode_ahb_sram_subordinate: WAIT_STATES must be 0..15");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_ERR1 = 2'd2,
        S_ERR2 = 2'd3
    } state_t;

    // Storage: no reset, contents survive HRESETn.
    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       be_q, be_d;
    logic             write_q, write_d;
    logic             hreadyout_q, hreadyout_d;
    logic             hresp_q, hresp_d;

    logic             accept;
    logic             illegal;
    logic             size_bad;
    logic             align_bad;
    logic             range_bad;
    logic [3:0]       be_new;
    logic             last_data;
    logic             commit;
    logic             rd_final;

    // HTRANS[0] (SEQ vs NONSEQ) and HBURST carry no meaning here: every beat
    // is handled on its own.
    logic unused_ok;
    assign unused_ok = ^{HTRANS[0], HBURST};

    assign accept    = HSEL && HTRANS[1] && HREADY;
    assign size_bad  = HSIZE > 3'd2;
    assign align_bad = ((HSIZE == 3'd1) && HADDR[0]) ||
                       ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
    assign range_bad = {1'b0, HADDR} >= BYTE_LIMIT;
    assign illegal   = size_bad || align_bad || range_bad;

    // Final cycle of an OKAY data phase: writes commit and reads are presented.
    assign last_data = (state_q == S_DATA) && (cnt_q == 4'd0);
    assign commit    = last_data && write_q;
    assign rd_final  = last_data && !write_q;

    // Little-endian byte-lane enables for the transfer in its address phase.
    always_comb begin
        be_new = 4'b0000;
        case (HSIZE)
            3'd0:    be_new = 4'b0001 << HADDR[1:0];
            3'd1:    be_new = HADDR[1] ? 4'b1100 : 4'b0011;
            default: be_new = 4'b1111;
        endcase
    end

    // Next-state logic: data-phase sequencing and address-phase capture.
    always_comb begin
        logic take;
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        be_d    = be_q;
        write_d = write_q;
        take    = 1'b0;

        case (state_q)
            S_IDLE: take = 1'b1;
            S_DATA: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    take = 1'b1;
                end
            end
            S_ERR1: state_d = S_ERR2;
            S_ERR2: take = 1'b1;
            default: state_d = S_IDLE;
        endcase

        if (take) begin
            if (accept && illegal) begin
                state_d = S_ERR1;
                cnt_d   = 4'd0;
                write_d = 1'b0;
            end else if (accept) begin
                state_d = S_DATA;
                cnt_d   = WS;
                idx_d   = HADDR[IDX_W+1:2];
                be_d    = be_new;
                write_d = HWRITE;
            end else begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
                write_d = 1'b0;
            end
        end

        // Outputs are registered, so derive them from the state being entered.
        hreadyout_d = !((state_d == S_ERR1) || ((state_d == S_DATA) && (cnt_d != 4'd0)));
        hresp_d     = (state_d == S_ERR1) || (state_d == S_ERR2);
    end

    // FSM state, transfer attributes and registered handshake outputs.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            idx_q       <= '0;
            be_q        <= 4'b0000;
            write_q     <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            be_q        <= be_d;
            write_q     <= write_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
        end
    end

    // Byte-lane write on the edge that ends the write data phase; a reset
    // forces IDLE first, which drops any write still pending.
    always_ff @(posedge HCLK) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

    // Read data is driven straight from the array so a read issued right after
    // a write to the same word sees the committed value without forwarding.
    assign HRDATA    = rd_final ? mem[idx_q] : '0;
    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;

endmodule

// File: doc/renode_ahb_sram_subordinate.md
# renode_ahb_sram_subordinate

Synthesizable AHB-Lite subordinate that answers transfers issued by an AHB manager (e.g. the Renode-driven AHB manager in co-simulation) with a word-organised on-chip memory. Supports byte/halfword/word accesses, a configurable number of wait states, and the two-cycle AHB ERROR response for illegal accesses. Sits on the `renode_ahb_if` signal set as the responder end of the bus, so manager-side bridges can be exercised against a known-good target.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, width of HADDR.
- `DATA_WIDTH`, 32, width of HWDATA/HRDATA; only 32 is supported; any other value is a elaboration-time `$error`.
- `MEM_WORDS`, 1024, memory depth in 32-bit words; legal byte range is 0 .. 4*MEM_WORDS-1.
- `WAIT_STATES`, 0, HREADYOUT-low cycles inserted in every OKAY data phase (0..15).

Ports:
- `HCLK` in 1: bus clock; all state changes on its rising edge.
- `HRESETn` in 1: asynchronous, active-low reset.
- `HSEL` in 1: subordinate select.
- `HADDR` in ADDR_WIDTH: byte address (address phase).
- `HTRANS` in 2: 0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
- `HWRITE` in 1: 1 write, 0 read.
- `HSIZE` in 3: 0 byte, 1 halfword, 2 word.
- `HBURST` in 3: accepted, ignored (each beat handled independently).
- `HWDATA` in DATA_WIDTH: write data (data phase).
- `HREADY` in 1: bus-level ready; qualifies address-phase sampling.
- `HREADYOUT` out 1: this subordinate's ready.
- `HRESP` out 1: 0 OKAY, 1 ERROR.
- `HRDATA` out DATA_WIDTH: read data.

## Operation
- Address phase accepted on a rising edge where `HSEL && HTRANS[1] && HREADY`; registers address, size, write flag. IDLE/BUSY or HSEL=0 -> no transfer, next data phase zero-wait OKAY.
- Error check at acceptance: HSIZE>2; halfword with HADDR[0]=1; word with HADDR[1:0]!=0; HADDR >= 4*MEM_WORDS. Any hit -> ERROR, memory untouched.
- FSM states:
  - IDLE: HREADYOUT=1, HRESP=0. Accepted legal -> DATA (load wait counter = WAIT_STATES); accepted illegal -> ERR1.
  - DATA: HREADYOUT = (cnt==0), HRESP=0; cnt decrements while nonzero. On cnt==0 edge: write commits, then new accepted transfer -> DATA/ERR1, else IDLE.
  - ERR1: HREADYOUT=0, HRESP=1; unconditionally -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1; new accepted transfer -> DATA/ERR1, else IDLE.
- Writes: little-endian byte lanes. Byte writes lane HADDR[1:0], halfword writes lanes {HADDR[1],0}+1..0, word writes all four. HWDATA sampled on the edge ending the data phase. Other lanes preserved.
- Reads: HRDATA = full 32-bit word at addr[..:2] during the final (HREADYOUT=1) DATA cycle; 0 in all other cycles, including ERR1/ERR2.
- Memory array has no reset; contents survive HRESETn.

## Timing
- Reset values (async, immediate): HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, counter=0.
- OKAY latency: data phase lasts WAIT_STATES+1 cycles after address phase.
- ERROR: exactly two data-phase cycles (HREADYOUT 0 then 1, HRESP 1 both), independent of WAIT_STATES.
- Back-to-back pipelining: the address phase of transfer N+1 overlaps the final data cycle of N; no bubble when WAIT_STATES=0.
- Write followed immediately by read of same word: write commits on the edge ending the write data phase, so the read data phase returns the new value (no forwarding needed).
- Reset mid-transfer: pending write is dropped (not committed); outputs return to reset values asynchronously.
- Address sampled while HREADY=0 is ignored.

## Test plan
- Reset: assert HRESETn=0 mid-DATA of a write to 0x10 (WAIT_STATES=2) -> HREADYOUT=1, HRESP=0, HRDATA=0 immediately; later read of 0x10 returns pre-write value.
- Word write 0xDEADBEEF to 0x20, then back-to-back read of 0x20, WAIT_STATES=0 -> read data phase one cycle, HRDATA=0xDEADBEEF, HRESP=0.
- Byte write 0xAA to 0x21 and halfword write 0x1234 to 0x22 over word 0x00000000 -> word read of 0x20 returns 0x1234AA00.
- WAIT_STATES=3, read of 0x0 -> HREADYOUT low 3 cycles then high 1 cycle with valid data.
- Read of 4*MEM_WORDS, word write to 0x2, HSIZE=3 -> each gives HRESP=1 for two cycles, HREADYOUT 0 then 1; memory unchanged.
- HTRANS=IDLE and BUSY with HSEL=1, and NONSEQ with HSEL=0 -> HREADYOUT=1, HRESP=0, no memory change.
